// File: rtl/set_cond_pkg.sv
// Shared definitions for the set-on-condition unit: op encodings, the reserved-op
// test and the stage-1 control payload.
package set_cond_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SEQ = 3'b000;
    localparam logic [OP_W-1:0] OP_SNE = 3'b001;
    localparam logic [OP_W-1:0] OP_SLT = 3'b010;
    localparam logic [OP_W-1:0] OP_SGT = 3'b011;
    localparam logic [OP_W-1:0] OP_SLE = 3'b100;
    localparam logic [OP_W-1:0] OP_SGE = 3'b101;

    // The tag width is a module parameter, so the tag is registered next to this payload.
    typedef struct packed {
        logic            eq;
        logic            lt;
        logic [OP_W-1:0] op;
        logic            illegal;
    } s1_ctrl_t;

    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/set_cond_cmp.sv
// Combinational magnitude comparator producing equality, unsigned/signed less-than,
// signed overflow and the sign of A-B; reusable by branch-compare logic.
module set_cond_cmp
    import set_cond_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             ult,
    output logic             slt,
    output logic             ovf,
    output logic             neg
);

    logic [WIDTH:0] diff_s;

    // Subtract with one guard bit so the top bit is the unsigned borrow.
    always_comb begin
        diff_s = {1'b0, a} - {1'b0, b};
        eq     = (a == b);
        ult    = diff_s[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
        slt    = diff_s[WIDTH-1] ^ ovf;
        neg    = diff_s[WIDTH-1];
    end

endmodule

// File: rtl/set_cond_unit.sv
// Two-stage pipelined set-on-condition unit with valid/ready on both sides.
// Optional condition flags output is built when SET_COND_FLAGS_EN is defined.
module set_cond_unit
    import set_cond_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_sgn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_set,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef SET_COND_FLAGS_EN
    ,
    output logic [3:0]       out_flags
`endif
);

    logic             eq_s;
    logic             ult_s;
    logic             slt_s;
    logic             ovf_s;
    logic             neg_s;

    logic             s1_valid_r;
    s1_ctrl_t         s1_ctrl_r;
    s1_ctrl_t         s1_next_s;
    logic [TAG_W-1:0] s1_tag_r;
    logic             s2_valid_r;

    logic             s2_en_s;
    logic             s1_en_s;
    logic             in_xfer_s;
    logic             cond_s;

    set_cond_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a   (in_a),
        .b   (in_b),
        .eq  (eq_s),
        .ult (ult_s),
        .slt (slt_s),
        .ovf (ovf_s),
        .neg (neg_s)
    );

    // Handshake: a stage advances when its successor is empty or moving.
    always_comb begin
        s2_en_s   = !s2_valid_r || out_ready;
        s1_en_s   = !s1_valid_r || s2_en_s;
        in_ready  = s1_en_s;
        in_xfer_s = in_valid && s1_en_s;
        out_valid = s2_valid_r;
    end

    // Stage-1 payload built from the comparator results.
    always_comb begin
        s1_next_s         = {$bits(s1_ctrl_t){1'b0}};
        s1_next_s.eq      = eq_s;
        s1_next_s.op      = in_op;
        s1_next_s.illegal = is_reserved_op(in_op);
        if (in_sgn) begin
            s1_next_s.lt = slt_s;
        end else begin
            s1_next_s.lt = ult_s;
        end
    end

    // Stage-1 registers: capture on input transfer, empty when drained with no new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_ctrl_r  <= {$bits(s1_ctrl_t){1'b0}};
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (s1_en_s) begin
            s1_valid_r <= in_xfer_s;
            if (in_xfer_s) begin
                s1_ctrl_r <= s1_next_s;
                s1_tag_r  <= in_tag;
            end
        end
    end

    // Condition select; reserved encodings never set the result.
    always_comb begin
        cond_s = 1'b0;
        case (s1_ctrl_r.op)
            OP_SEQ:  cond_s = s1_ctrl_r.eq;
            OP_SNE:  cond_s = !s1_ctrl_r.eq;
            OP_SLT:  cond_s = s1_ctrl_r.lt;
            OP_SGT:  cond_s = !s1_ctrl_r.lt && !s1_ctrl_r.eq;
            OP_SLE:  cond_s = s1_ctrl_r.lt || s1_ctrl_r.eq;
            OP_SGE:  cond_s = !s1_ctrl_r.lt;
            default: cond_s = 1'b0;
        endcase
    end

    // Stage-2 output registers; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            out_set     <= {WIDTH{1'b0}};
            out_tag     <= {TAG_W{1'b0}};
            out_illegal <= 1'b0;
        end else if (s2_en_s) begin
            s2_valid_r  <= s1_valid_r;
            out_set     <= {{(WIDTH-1){1'b0}}, cond_s};
            out_tag     <= s1_tag_r;
            out_illegal <= s1_ctrl_r.illegal;
        end
    end

`ifdef SET_COND_FLAGS_EN
    // N, C (no-borrow) and V; Z is taken from the stored equality bit.
    logic [2:0] s1_ncv_r;

    // Stage-1 flag capture, moving in lockstep with the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ncv_r <= 3'b000;
        end else if (s1_en_s && in_xfer_s) begin
            s1_ncv_r <= {neg_s, !ult_s, ovf_s};
        end
    end

    // Stage-2 flag output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= 4'b0000;
        end else if (s2_en_s) begin
            out_flags <= {s1_ctrl_r.eq, s1_ncv_r};
        end
    end
`else
    logic unused_flag_s;
    assign unused_flag_s = neg_s ^ ovf_s;
`endif

endmodule

// File: tb/tb_set_cond_unit.sv
// Directed self-checking bench for set_cond_unit (WIDTH=32, TAG_W=5).
module tb_set_cond_unit;
    import set_cond_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_sgn;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_set;
    logic [4:0]  out_tag;
    logic        out_illegal;
`ifdef SET_COND_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    set_cond_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_sgn      (in_sgn),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_set     (out_set),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
`ifdef SET_COND_FLAGS_EN
        ,
        .out_flags   (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string sfx, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s_%s observed=%0h expected=%0h", nm, sfx, obs, exp);
        end
    endtask

    // Single request into an empty pipeline with out_ready high.
    task automatic one(input string nm, input logic [2:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic exp_set, input logic exp_ill);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_sgn    = sgn;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        #1;
        chk(nm, "rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(nm, "lat1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk(nm, "valid", {63'd0, out_valid}, 64'd1);
        chk(nm, "set", {32'd0, out_set}, {63'd0, exp_set});
        chk(nm, "tag", {59'd0, out_tag}, {59'd0, tag});
        chk(nm, "ill", {63'd0, out_illegal}, {63'd0, exp_ill});
        @(posedge clk); #1;
        chk(nm, "drain", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int next_tag;
        int delivered;
        int occ;
        logic acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_sgn    = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        #12;
        chk("rst", "valid", {63'd0, out_valid}, 64'd0);
        chk("rst", "set", {32'd0, out_set}, 64'd0);
        chk("rst", "tag", {59'd0, out_tag}, 64'd0);
        chk("rst", "ill", {63'd0, out_illegal}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst", "rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        one("uslt",  OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b0, 1'b0);
        one("sslt",  OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1, 1'b0);

        one("eq_seq", OP_SEQ, 1'b0, 32'd7, 32'd7, 5'd4, 1'b1, 1'b0);
        one("eq_sne", OP_SNE, 1'b0, 32'd7, 32'd7, 5'd5, 1'b0, 1'b0);
        one("eq_slt", OP_SLT, 1'b0, 32'd7, 32'd7, 5'd6, 1'b0, 1'b0);
        one("eq_sgt", OP_SGT, 1'b0, 32'd7, 32'd7, 5'd7, 1'b0, 1'b0);
        one("eq_sle", OP_SLE, 1'b0, 32'd7, 32'd7, 5'd8, 1'b1, 1'b0);
        one("eq_sge", OP_SGE, 1'b0, 32'd7, 32'd7, 5'd9, 1'b1, 1'b0);

        one("lt_seq", OP_SEQ, 1'b1, 32'd5, 32'd9, 5'd10, 1'b0, 1'b0);
        one("lt_sne", OP_SNE, 1'b1, 32'd5, 32'd9, 5'd11, 1'b1, 1'b0);
        one("lt_slt", OP_SLT, 1'b1, 32'd5, 32'd9, 5'd12, 1'b1, 1'b0);
        one("lt_sgt", OP_SGT, 1'b1, 32'd5, 32'd9, 5'd13, 1'b0, 1'b0);
        one("lt_sle", OP_SLE, 1'b1, 32'd5, 32'd9, 5'd14, 1'b1, 1'b0);
        one("lt_sge", OP_SGE, 1'b1, 32'd5, 32'd9, 5'd15, 1'b0, 1'b0);

        one("ovf_s", OP_SGT, 1'b1, 32'h8000_0000, 32'd1, 5'd16, 1'b0, 1'b0);
        one("ovf_u", OP_SGT, 1'b0, 32'h8000_0000, 32'd1, 5'd17, 1'b1, 1'b0);
        one("gt_s",  OP_SGT, 1'b1, 32'd1, 32'hFFFF_FFFF, 5'd18, 1'b1, 1'b0);

        one("rsv6", 3'b110, 1'b0, 32'd7, 32'd7, 5'd3, 1'b0, 1'b1);
        one("rsv7", 3'b111, 1'b1, 32'd1, 32'd2, 5'd19, 1'b0, 1'b1);

`ifdef SET_COND_FLAGS_EN
        one("flg", OP_SLT, 1'b0, 32'd0, 32'd1, 5'd20, 1'b1, 1'b0);
        // Output register still holds the last result after draining.
        chk("flg", "zncv", {60'd0, out_flags}, 64'h4);
`endif

        // Backpressure: tags 1..6 streamed, consumer stalled in cycles 2-6.
        next_tag  = 1;
        delivered = 0;
        occ       = 0;
        for (int c = 1; c <= 40 && delivered < 6; c++) begin
            out_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            in_valid  = (next_tag <= 6);
            in_op     = OP_SLT;
            in_sgn    = 1'b0;
            in_a      = 32'(next_tag);
            in_b      = 32'd3;
            in_tag    = 5'(next_tag);
            #1;
            chk("bp", "rdy", {63'd0, in_ready}, {63'd0, (occ < 2) || out_ready});
            if (out_valid) begin
                chk("bp", "order", {59'd0, out_tag}, 64'(delivered + 1));
                chk("bp", "data", {32'd0, out_set}, {63'd0, (delivered + 1) < 3});
                if (out_ready) begin
                    delivered++;
                    occ--;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                next_tag++;
                occ++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp", "count", 64'(delivered), 64'd6);
        chk("bp", "accepted", 64'(next_tag), 64'd7);
        @(posedge clk); #1;
        chk("bp", "nodup", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with two requests in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_SEQ;
        in_a      = 32'd1;
        in_b      = 32'd1;
        in_tag    = 5'd9;
        @(posedge clk); #1;
        in_tag = 5'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("arst", "pre", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst", "valid", {63'd0, out_valid}, 64'd0);
        chk("arst", "tag", {59'd0, out_tag}, 64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("arst", "rdy", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("arst", "stale", {63'd0, out_valid}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
